// File: rtl/pooling_pkg.sv
// Shared types for the 2x2 stride-2 pooling stream: pool mode, FSM states
// and the default pixel width.
package pooling_pkg;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pool_state_e;
endpackage

// File: rtl/pool_combine.sv
// Combinational pooling reduction. With i_final low it reduces a horizontal pixel
// pair; with i_final high it folds a stored pair result into a full 2x2 window.
module pool_combine
    import pooling_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  pool_mode_e               i_mode,
    input  logic                     i_final,
    input  logic signed [DATA_W:0]   i_part,
    input  logic signed [DATA_W-1:0] i_left,
    input  logic signed [DATA_W-1:0] i_right,
    output logic signed [DATA_W:0]   o_result
);
    logic signed [DATA_W:0]   w_pair_sum;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W:0]   w_pair_max_ext;
    logic signed [DATA_W:0]   w_quad_max;
    logic signed [DATA_W+1:0] w_sum;
    logic signed [DATA_W+1:0] w_sum_adj;
    logic signed [DATA_W+1:0] w_quot;

    always_comb begin
        w_pair_sum     = {i_left[DATA_W-1], i_left} + {i_right[DATA_W-1], i_right};
        w_pair_max     = (i_left > i_right) ? i_left : i_right;
        w_pair_max_ext = {w_pair_max[DATA_W-1], w_pair_max};
        w_quad_max     = (i_part > w_pair_max_ext) ? i_part : w_pair_max_ext;
        w_sum          = {i_part[DATA_W], i_part}
                       + {{2{i_left[DATA_W-1]}}, i_left}
                       + {{2{i_right[DATA_W-1]}}, i_right};
        // Bias negative sums by 3 so the arithmetic shift truncates toward zero.
        w_sum_adj      = w_sum[DATA_W+1] ? (w_sum + (DATA_W+2)'(3)) : w_sum;
        w_quot         = w_sum_adj >>> 2;

        o_result = '0;
        if (!i_final)
            o_result = (i_mode == POOL_AVG) ? w_pair_sum : w_pair_max_ext;
        else
            o_result = (i_mode == POOL_AVG) ? w_quot[DATA_W:0] : w_quad_max;
    end
endmodule

// File: rtl/pooling_stream.sv
// Streaming 2x2 stride-2 average/max pooling over a raster-order frame, with
// valid/ready handshakes on both sides and a one-row line buffer of pair results.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; mode and counters are loaded on start
//   ST_RUN  | accepting pixels and emitting pooled results
//   ST_DONE | one-cycle done pulse, then back to ST_IDLE
module pooling_stream
    import pooling_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_pixel,
    output logic                     busy,
    output logic                     done
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int NW    = $clog2(TOTAL + 1);
    localparam int LBN   = IMG_W / 2;
    localparam int LBW   = (LBN > 1) ? $clog2(LBN) : 1;

    pool_state_e              r_state;
    pool_mode_e               r_mode;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [NW-1:0]            r_in_cnt;
    logic signed [DATA_W-1:0] r_hold;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_pixel;
    logic signed [DATA_W:0]   r_line [LBN];

    logic                     w_in_ready;
    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic                     w_last_out;
    logic                     w_lb_we;
    logic [LBW-1:0]           w_lb_idx;
    logic signed [DATA_W:0]   w_pair;
    logic signed [DATA_W:0]   w_quad;

    assign w_in_ready = (r_state == ST_RUN) && !(r_out_valid && !out_ready)
                        && (r_in_cnt < NW'(TOTAL));
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    // Once every input is in, the pending result is the frame's last one.
    assign w_last_out = w_out_xfer && (r_in_cnt == NW'(TOTAL));
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_lb_we    = w_in_xfer && !r_row[0] && r_col[0];

    pool_combine #(.DATA_W(DATA_W)) u_pair (
        .i_mode   (r_mode),
        .i_final  (1'b0),
        .i_part   ('0),
        .i_left   (r_hold),
        .i_right  (in_pixel),
        .o_result (w_pair)
    );

    pool_combine #(.DATA_W(DATA_W)) u_quad (
        .i_mode   (r_mode),
        .i_final  (1'b1),
        .i_part   (r_line[w_lb_idx]),
        .i_left   (r_hold),
        .i_right  (in_pixel),
        .o_result (w_quad)
    );

    always_ff @(posedge clk) begin
        if (w_lb_we)
            r_line[w_lb_idx] <= w_pair;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= POOL_AVG;
            r_col       <= '0;
            r_row       <= '0;
            r_in_cnt    <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_mode      <= pool_mode_e'(mode);
                        r_col       <= '0;
                        r_row       <= '0;
                        r_in_cnt    <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_in_xfer) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_col == CW'(IMG_W - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (!r_col[0])
                            r_hold <= in_pixel;
                    end
                    // A new result overrides the clear so back-to-back windows see no bubble.
                    if (w_in_xfer && r_row[0] && r_col[0]) begin
                        r_out_valid <= 1'b1;
                        r_out_pixel <= w_quad[DATA_W-1:0];
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_last_out)
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_pooling_stream.sv
// Scoreboard bench for pooling_stream on a 4x4 frame: directed frames with
// hand-computed results, stall/reset scenarios, then random frames vs. a window model.
module tb_pooling_stream;
    typedef logic signed [15:0] frame_t [16];

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               mode = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_pixel = '0;
    logic               out_ready = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] out_pixel;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic signed [15:0] exp_q [$];
    logic signed [15:0] exp_v;

    pooling_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0d, required no output", out_pixel);
            end else begin
                exp_v = exp_q.pop_front();
                check("out_pixel", int'(out_pixel), int'(exp_v));
            end
        end
    end

    function automatic void model(input frame_t px, input bit m);
        int a, b, c, d, r;
        for (int wr = 0; wr < 2; wr++) begin
            for (int wc = 0; wc < 2; wc++) begin
                a = px[(2*wr)*4 + 2*wc];
                b = px[(2*wr)*4 + 2*wc + 1];
                c = px[(2*wr+1)*4 + 2*wc];
                d = px[(2*wr+1)*4 + 2*wc + 1];
                if (m) begin
                    r = a;
                    if (b > r) r = b;
                    if (c > r) r = c;
                    if (d > r) r = d;
                end else begin
                    r = (a + b + c + d) / 4;
                end
                exp_q.push_back(16'(r));
            end
        end
    endfunction

    task automatic start_frame(input bit m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic signed [15:0] v);
        in_valid = 1'b1;
        in_pixel = v;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            if (t > 2000) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t px, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_pixel(px[i]);
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_pulse", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t seq, rev, f;
        int done_before;
        for (int i = 0; i < 16; i++) begin
            seq[i] = 16'(i);
            rev[i] = 16'(15 - i);
        end

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Average of 0..15
        start_frame(1'b0);
        check("busy_in_run", int'(busy), 1);
        exp_q.push_back(16'sd2);  exp_q.push_back(16'sd4);
        exp_q.push_back(16'sd10); exp_q.push_back(16'sd12);
        send_frame(seq, 1'b0, 16);
        wait_done();

        // Max of 0..15
        start_frame(1'b1);
        exp_q.push_back(16'sd5);  exp_q.push_back(16'sd7);
        exp_q.push_back(16'sd13); exp_q.push_back(16'sd15);
        send_frame(seq, 1'b0, 16);
        wait_done();

        // Negative average truncates toward zero: sum -9 -> -2
        foreach (f[i]) f[i] = '0;
        f[0] = -16'sd1; f[1] = -16'sd2; f[4] = -16'sd3; f[5] = -16'sd3;
        start_frame(1'b0);
        exp_q.push_back(-16'sd2); exp_q.push_back(16'sd0);
        exp_q.push_back(16'sd0);  exp_q.push_back(16'sd0);
        send_frame(f, 1'b0, 16);
        wait_done();

        // Negative max
        foreach (f[i]) f[i] = '0;
        f[0] = -16'sd7; f[1] = -16'sd3; f[4] = -16'sd9; f[5] = -16'sd5;
        start_frame(1'b1);
        exp_q.push_back(-16'sd3); exp_q.push_back(16'sd0);
        exp_q.push_back(16'sd0);  exp_q.push_back(16'sd0);
        send_frame(f, 1'b0, 16);
        wait_done();

        // Back-pressure at the first output; a start pulse mid-frame is ignored
        rdy_mode  = 2;
        out_ready = 1'b0;
        start_frame(1'b0);
        exp_q.push_back(16'sd2);  exp_q.push_back(16'sd4);
        exp_q.push_back(16'sd10); exp_q.push_back(16'sd12);
        fork
            send_frame(seq, 1'b0, 16);
            begin
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                check("stall_out_valid", int'(out_valid), 1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_out_pixel", int'(out_pixel), 2);
                    if (k == 1) begin start = 1'b1; mode = 1'b1; end
                    if (k == 2) start = 1'b0;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                rdy_mode  = 0;
            end
        join
        wait_done();

        // Reset mid-frame discards partial data
        done_before = done_cnt;
        rdy_mode  = 2;
        out_ready = 1'b0;
        start_frame(1'b0);
        send_frame(seq, 1'b0, 6);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("midrst_no_output", int'(out_valid), 0);
        check("midrst_no_done", done_cnt, done_before);
        start_frame(1'b1);
        exp_q.push_back(16'sd15); exp_q.push_back(16'sd13);
        exp_q.push_back(16'sd7);  exp_q.push_back(16'sd5);
        send_frame(rev, 1'b0, 16);
        wait_done();
        check("midrst_one_done", done_cnt, done_before + 1);

        // Random frames with random valid gaps and random ready
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            bit m;
            foreach (f[i]) f[i] = 16'($urandom);
            m = 1'($urandom_range(0, 1));
            start_frame(m);
            model(f, m);
            send_frame(f, 1'b1, 16);
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pooling_stream.md
POOLING_STREAM -- requirements
Module: pooling_stream

Interface
REQ-001 Parameter DATA_W, default 16, signed pixel width in bits.
REQ-002 Parameter IMG_W, default 28, pixels per input row; even, >= 2.
REQ-003 Parameter IMG_H, default 28, rows per input frame; even, >= 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a frame.
REQ-007 mode  in  1  0 = average pool, 1 = max pool; sampled only with start.
REQ-008 in_valid  in  1  in_pixel is valid.
REQ-009 in_ready  out  1  block accepts in_pixel this cycle.
REQ-010 in_pixel  in  DATA_W  signed input pixel, raster order (row-major).
REQ-011 out_valid  out  1  out_pixel is valid.
REQ-012 out_ready  in  1  consumer accepts out_pixel this cycle.
REQ-013 out_pixel  out  DATA_W  signed pooled pixel, raster order.
REQ-014 busy  out  1  high while a frame is in progress.
REQ-015 done  out  1  one-cycle pulse after the last pooled pixel of a frame is accepted.

Function
REQ-016 The block SHALL perform 2x2 pooling, stride 2, producing (IMG_W/2)x(IMG_H/2) outputs per frame.
REQ-017 FSM states: IDLE, RUN, DONE; IDLE->RUN on start (counters cleared, mode latched); RUN->DONE when the final output handshake completes; DONE->IDLE after exactly one cycle.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 An input transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
REQ-020 in_ready = (state==RUN) && !(out_valid && !out_ready) && (input count < IMG_W*IMG_H).
REQ-021 Even rows: at each odd column, the pair (previous pixel, current pixel) SHALL be combined and stored in a line buffer of IMG_W/2 entries, indexed col/2.
REQ-022 Odd rows: even-column pixels are held in a register; at each odd column the final window result is computed from line buffer[col/2], the held pixel and the current pixel.
REQ-023 Average: 4-pixel sum in DATA_W+2 bits, signed, divided by 4 truncating toward zero; result fits DATA_W without saturation.
REQ-024 Max: signed maximum of the 4 pixels; line-buffer entries hold DATA_W+1 bits to cover the average-mode partial sum.
REQ-025 out_valid SHALL rise on the cycle after the input transfer of each window's bottom-right pixel and hold with out_pixel stable until the output transfer.
REQ-026 Column counter wraps IMG_W-1 -> 0 and increments the row counter; row counter does not wrap within a frame.
REQ-027 Simultaneous output transfer and completing input transfer SHALL load the new result with no bubble (full throughput, 1 input/cycle).
REQ-028 busy SHALL be high in RUN and low in IDLE and DONE; done SHALL be high only in DONE.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, counters=0, out_valid=0, out_pixel=0, in_ready=0, busy=0, done=0, latched mode=0.
REQ-030 Reset mid-frame SHALL discard all partial data; no output or done follows until a new start.
REQ-031 Line-buffer contents need no reset; they are always written before being read.

Structure
REQ-032 Package pooling_pkg SHALL hold the pool-mode enum (POOL_AVG=0, POOL_MAX=1), the FSM state enum and the default DATA_W.
REQ-033 Sub-module pool_combine (combinational: mode, operands -> sum or max, with divide for the final stage) SHALL be instantiated for both the horizontal and the final combine.

Verification
REQ-034 IMG_W=IMG_H=4, avg, pixels 0..15 raster, out_ready=1 -> outputs 2,4,10,12, then done pulse, busy low.
REQ-035 Same frame, max mode -> outputs 5,7,13,15.
REQ-036 Avg window {-1,-2,-3,-3} -> sum -9, out_pixel -2 (truncate toward zero); max window {-7,-3,-9,-5} -> -3.
REQ-037 out_ready held low for 5 cycles at the first output -> in_ready low while blocked, out_pixel stable, no data loss, outputs in order.
REQ-038 rst_n pulsed low after 6 inputs, then restarted with start -> first frame's data discarded, new frame's outputs correct, exactly one done pulse.
REQ-039 300 random frames (DATA_W=16, values -32768..32767, random valid/ready) vs. reference model -> zero mismatches.
